// File: rtl/player_sprite_engine_if.sv
// Video stream bundle: pixel counters, sync/blank timing and RGB.
// Modports:
//   master - drives the stream (upstream stage, or this engine's output)
//   slave  - consumes the stream (this engine's input)
interface player_sprite_engine_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/player_sprite_engine.sv
// Player sprite overlay: composites head, two-frame legs and sword over the
// background stream with a 2-stage pipeline matched to 1-cycle sync ROMs.
// Positions are latched at the vsync rising edge so a frame never tears.
// Ports:
//   clk, reset          pixel clock, async active-high reset
//   vga_in  (slave)     incoming counters/timing/background pixel
//   vga_out (master)    same stream delayed 2 clocks, composited rgb
//   x_pos, y_pos        player offsets; sword_x, sword_y sword offsets
//   walking             enables leg animation
//   rom_*               sprite ROM data, valid 1 clock after addr_*
//   addr_head/legs/sword {row,col} ROM addresses (1 clock after inputs)
//   xpos_out..ypos_sword latched screen positions
//   leg_frame, hit      animation frame, one-cycle hit pulse at frame start
// Optional build macro: SPRITE_MIRROR_EN adds input 'facing' (horizontal flip).
module player_sprite_engine #(
  parameter int          SPR_W       = 64,
  parameter int          SPR_H       = 64,
  parameter int          SWD_SZ      = 32,
  parameter logic [11:0] KEY_COLOR   = 12'h198,
  parameter logic [11:0] SWORD_COLOR = 12'h000,
  parameter logic [11:0] OPP_COLOR   = 12'hcf0,
  parameter int          BASE_X      = 885,
  parameter int          BASE_Y      = 600,
  parameter int          ANIM_DIV    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  player_sprite_engine_if.slave              vga_in,
  player_sprite_engine_if.master             vga_out,
  input  logic [11:0]                        x_pos,
  input  logic [11:0]                        y_pos,
  input  logic [4:0]                         sword_y,
  input  logic [11:0]                        sword_x,
  input  logic                               walking,
`ifdef SPRITE_MIRROR_EN
  input  logic                               facing,
`endif
  input  logic [11:0]                        rom_head,
  input  logic [11:0]                        rom_head2,
  input  logic [11:0]                        rom_legs,
  input  logic [11:0]                        rom_legs2,
  input  logic [11:0]                        rom_sword,
  output logic [$clog2(SPR_W*SPR_H)-1:0]     addr_head,
  output logic [$clog2(SPR_W*SPR_H)-1:0]     addr_legs,
  output logic [2*$clog2(SWD_SZ)-1:0]        addr_sword,
  output logic [11:0]                        xpos_out,
  output logic [11:0]                        ypos_out,
  output logic [11:0]                        xpos_sword,
  output logic [11:0]                        ypos_sword,
  output logic                               leg_frame,
  output logic                               hit
);
  localparam int          CW        = $clog2(SPR_W);
  localparam int          RW        = $clog2(SPR_H);
  localparam int          SW        = $clog2(SWD_SZ);
  localparam logic [11:0] W12       = 12'(SPR_W);
  localparam logic [11:0] H12       = 12'(SPR_H);
  localparam logic [11:0] S12       = 12'(SWD_SZ);
  localparam logic [11:0] BX        = 12'(BASE_X);
  localparam logic [11:0] BY        = 12'(BASE_Y);
  localparam logic [7:0]  ANIM_LAST = 8'(ANIM_DIV - 1);

  // Borrow-aware span test: a sprite whose origin lies past the counter
  // (wrapped negative position) is clipped instead of reappearing at 0.
  function automatic logic covers(input logic [11:0] pix, input logic [11:0] org,
                                  input logic [11:0] size);
    return (pix >= org) && ((pix - org) < size);
  endfunction

  logic        vsync_q, frame_start;
  logic [11:0] hx_n, hy_n, swx_n, swy_n;
  logic [11:0] head_x, head_y, legs_y, sword_xs, sword_ys;
  logic [4:0]  sword_y_q;
  logic        mirror;
  logic [7:0]  anim_cnt;
  logic        hit_acc;

  assign frame_start = vga_in.vsync & ~vsync_q;

  assign hx_n  = BX - x_pos;
  assign hy_n  = BY - y_pos;
  assign swy_n = hy_n + H12 - 12'd9 - {7'd0, sword_y};
`ifdef SPRITE_MIRROR_EN
  logic facing_q;
  assign mirror = facing_q;
  assign swx_n  = facing ? (hx_n + W12 + sword_x) : (hx_n - S12 - sword_x);
`else
  assign mirror = 1'b0;
  assign swx_n  = hx_n - S12 - sword_x;
`endif

  assign legs_y     = head_y + H12;
  assign xpos_out   = head_x;
  assign ypos_out   = head_y;
  assign xpos_sword = sword_xs;
  assign ypos_sword = sword_ys;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q   <= 1'b0;
      head_x    <= BX;
      head_y    <= BY;
      sword_xs  <= BX - S12;
      sword_ys  <= BY + H12 - 12'd9;
      sword_y_q <= '0;
`ifdef SPRITE_MIRROR_EN
      facing_q  <= 1'b0;
`endif
    end else begin
      vsync_q <= vga_in.vsync;
      if (frame_start) begin
        head_x    <= hx_n;
        head_y    <= hy_n;
        sword_xs  <= swx_n;
        sword_ys  <= swy_n;
        sword_y_q <= sword_y;
`ifdef SPRITE_MIRROR_EN
        facing_q  <= facing;
`endif
      end
    end
  end

  // Stage 1: coverage and ROM addressing
  logic [11:0]   dx_h, dy_h, dy_l, dx_s, dy_s;
  logic [CW-1:0] col_h;
  logic [SW-1:0] col_s;
  logic          in_head_q, in_legs_q, in_sword_q;
  logic [11:0]   rgb_q, hc_q, vc_q;
  logic          hs_q, vs_q, hb_q, vb_q;

  assign dx_h = vga_in.hcount - head_x;
  assign dy_h = vga_in.vcount - head_y;
  assign dy_l = vga_in.vcount - legs_y;
  assign dx_s = vga_in.hcount - sword_xs;
  assign dy_s = vga_in.vcount - sword_ys;
  // W is a power of two, so W-1-dx within the column field is just ~dx.
  assign col_h = mirror ? ~dx_h[CW-1:0] : dx_h[CW-1:0];
  assign col_s = mirror ? ~dx_s[SW-1:0] : dx_s[SW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_head  <= '0;
      addr_legs  <= '0;
      addr_sword <= '0;
      in_head_q  <= 1'b0;
      in_legs_q  <= 1'b0;
      in_sword_q <= 1'b0;
      rgb_q      <= '0;
      hc_q       <= '0;
      vc_q       <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      hb_q       <= 1'b0;
      vb_q       <= 1'b0;
    end else begin
      addr_head  <= {dy_h[RW-1:0], col_h};
      addr_legs  <= {dy_l[RW-1:0], col_h};
      addr_sword <= {dy_s[SW-1:0], col_s};
      in_head_q  <= covers(vga_in.hcount, head_x, W12) && covers(vga_in.vcount, head_y, H12);
      in_legs_q  <= covers(vga_in.hcount, head_x, W12) && covers(vga_in.vcount, legs_y, H12);
      in_sword_q <= covers(vga_in.hcount, sword_xs, S12) && covers(vga_in.vcount, sword_ys, S12);
      rgb_q      <= vga_in.rgb;
      hc_q       <= vga_in.hcount;
      vc_q       <= vga_in.vcount;
      hs_q       <= vga_in.hsync;
      vs_q       <= vga_in.vsync;
      hb_q       <= vga_in.hblnk;
      vb_q       <= vga_in.vblnk;
    end
  end

  // Stage 2: compositing with ROM data
  logic [11:0] head_pix, legs_pix, rgb_nxt;
  logic        head_on, legs_on, sword_on, overlap;

  assign head_pix = (sword_y_q != 5'd0) ? rom_head2 : rom_head;
  assign legs_pix = leg_frame ? rom_legs2 : rom_legs;
  assign head_on  = in_head_q && (head_pix != KEY_COLOR);
  assign legs_on  = in_legs_q && (legs_pix != KEY_COLOR);
  assign sword_on = in_sword_q && (rom_sword != KEY_COLOR);
  assign overlap  = sword_on && (rgb_q == OPP_COLOR);

  always_comb begin
    rgb_nxt = rgb_q;
    if (hb_q || vb_q) rgb_nxt = 12'h000;
    else if (head_on) rgb_nxt = head_pix;
    else if (legs_on) rgb_nxt = legs_pix;
    else if (sword_on) rgb_nxt = SWORD_COLOR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= hc_q;
      vga_out.vcount <= vc_q;
      vga_out.hsync  <= hs_q;
      vga_out.vsync  <= vs_q;
      vga_out.hblnk  <= hb_q;
      vga_out.vblnk  <= vb_q;
      vga_out.rgb    <= rgb_nxt;
    end
  end

  // Walk animation and per-frame hit reporting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anim_cnt  <= '0;
      leg_frame <= 1'b0;
      hit_acc   <= 1'b0;
      hit       <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (frame_start) begin
        hit     <= hit_acc;
        hit_acc <= overlap;   // overlap in the frame-start cycle counts for the new frame
        if (!walking) begin
          anim_cnt  <= '0;
          leg_frame <= 1'b0;
        end else if (anim_cnt == ANIM_LAST) begin
          anim_cnt  <= '0;
          leg_frame <= ~leg_frame;
        end else begin
          anim_cnt <= anim_cnt + 8'd1;
        end
      end else if (overlap) begin
        hit_acc <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_player_sprite_engine.sv
module tb_player_sprite_engine;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] x_pos, y_pos, sword_x;
  logic [4:0]  sword_y;
  logic        walking;
  logic [11:0] rom_head, rom_head2, rom_legs, rom_legs2, rom_sword;
  logic [11:0] addr_head, addr_legs;
  logic [9:0]  addr_sword;
  logic [11:0] xpos_out, ypos_out, xpos_sword, ypos_sword;
  logic        leg_frame, hit;
  logic        hit_at_start;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  player_sprite_engine_if vin ();
  player_sprite_engine_if vout ();

  player_sprite_engine #(.ANIM_DIV(2)) dut (
    .clk(clk), .reset(reset), .vga_in(vin), .vga_out(vout),
    .x_pos(x_pos), .y_pos(y_pos), .sword_y(sword_y), .sword_x(sword_x),
    .walking(walking),
    .rom_head(rom_head), .rom_head2(rom_head2), .rom_legs(rom_legs),
    .rom_legs2(rom_legs2), .rom_sword(rom_sword),
    .addr_head(addr_head), .addr_legs(addr_legs), .addr_sword(addr_sword),
    .xpos_out(xpos_out), .ypos_out(ypos_out), .xpos_sword(xpos_sword),
    .ypos_sword(ypos_sword), .leg_frame(leg_frame), .hit(hit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [11:0] expv);
    exp_q.push_back(expv);
    tag_q.push_back(tag);
  endtask

  task automatic pop_rgb();
    logic [11:0] e;
    string t;
    n_cmp++;
    assert (exp_q.size() > 0)
    else begin
      n_err++;
      $error("FAIL scoreboard_empty: observed rgb %h expected a queued entry", vout.rgb);
    end
    if (exp_q.size() > 0) begin
      n_cmp--;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, vout.rgb, e);
    end
  endtask

  task automatic settle2();
    tick();
    tick();
    pop_rgb();
  endtask

  task automatic frame();
    vin.vsync = 1'b1;
    tick();
    hit_at_start = hit;
    vin.vsync = 1'b0;
    tick();
  endtask

  task automatic pix(input logic [11:0] hc, input logic [11:0] vc, input logic [11:0] bg);
    vin.hcount = hc;
    vin.vcount = vc;
    vin.rgb    = bg;
  endtask

  logic walk_seq[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic lf_exp[10]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    vin.hcount = '0; vin.vcount = '0; vin.rgb = '0;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    x_pos = '0; y_pos = '0; sword_x = '0; sword_y = '0; walking = 1'b0;
    rom_head = 12'hf00; rom_head2 = 12'h0f0;
    rom_legs = 12'h198; rom_legs2 = 12'h198; rom_sword = 12'h198;
    hit_at_start = 1'b0;
    tick(); tick(); tick();

    chk("rst_rgb",    vout.rgb,   12'h000);
    chk("rst_xpos",   xpos_out,   12'd885);
    chk("rst_ypos",   ypos_out,   12'd600);
    chk("rst_xsword", xpos_sword, 12'd853);
    chk("rst_ysword", ypos_sword, 12'd655);
    chk("rst_lf",     12'(leg_frame), 12'd0);
    chk("rst_hit",    12'(hit), 12'd0);
    reset = 1'b0;

    // head origin pixel
    pix(12'd885, 12'd600, 12'h0a0);
    push("head_origin", 12'hf00);
    tick();
    chk("addr_head_origin", addr_head, 12'd0);
    tick();
    pop_rgb();
    chk("hcount_delay", vout.hcount, 12'd885);
    chk("vcount_delay", vout.vcount, 12'd600);

    // inner head pixel: row 3, col 5
    pix(12'd890, 12'd603, 12'h0a0);
    push("head_inner", 12'hf00);
    tick();
    chk("addr_head_inner", addr_head, 12'd197);
    tick();
    pop_rgb();

    // transparent head, then blanking
    pix(12'd885, 12'd600, 12'h0a0);
    rom_head = 12'h198;
    push("head_key", 12'h0a0);
    settle2();
    vin.hblnk = 1'b1;
    push("hblnk_black", 12'h000);
    settle2();
    chk("hblnk_delay", 12'(vout.hblnk), 12'd1);
    vin.hblnk = 1'b0;
    vin.vblnk = 1'b1;
    push("vblnk_black", 12'h000);
    settle2();
    vin.vblnk = 1'b0;
    push("unblank", 12'h0a0);
    settle2();

    // frame-latched position
    frame();
    x_pos = 12'd10;
    tick(); tick(); tick();
    chk("xpos_midframe", xpos_out, 12'd885);
    frame();
    chk("xpos_next_frame", xpos_out, 12'd875);
    chk("xsword_next_frame", xpos_sword, 12'd843);

    // walk animation with ANIM_DIV=2
    for (int i = 0; i < 10; i++) begin
      walking = walk_seq[i];
      frame();
      chk($sformatf("leg_frame_%0d", i), 12'(leg_frame), 12'(lf_exp[i]));
    end
    walking = 1'b0;

    // legs frame 1 at (875,664)
    rom_legs = 12'h111; rom_legs2 = 12'h222;
    pix(12'd875, 12'd664, 12'h0a0);
    push("legs_frame1", 12'h222);
    settle2();

    // hit detection
    x_pos = '0;
    frame();
    chk("lf_cleared", 12'(leg_frame), 12'd0);
    pix(12'd885, 12'd664, 12'h0a0);
    push("legs_frame0", 12'h111);
    settle2();
    pix(12'd853, 12'd655, 12'hcf0);
    rom_sword = 12'h000;
    push("sword_pixel", 12'h000);
    settle2();
    chk("hit_quiet_midframe", 12'(hit), 12'd0);
    pix(12'd0, 12'd0, 12'h0a0);
    rom_sword = 12'h198;
    tick(); tick(); tick();
    frame();
    chk("hit_pulse", 12'(hit_at_start), 12'd1);
    chk("hit_one_cycle", 12'(hit), 12'd0);
    tick();
    frame();
    chk("hit_no_repeat", 12'(hit_at_start), 12'd0);

    // guard head sprite selected by sword_y
    sword_y = 5'd3;
    frame();
    chk("ysword_guard", ypos_sword, 12'd652);
    rom_head = 12'hf00;
    pix(12'd885, 12'd600, 12'h0a0);
    push("head_guard", 12'h0f0);
    settle2();
    sword_y = '0;

    // wrapped position: no aliasing onto the left edge
    x_pos = 12'd900;
    frame();
    chk("xpos_wrap", xpos_out, 12'd4081);
    for (int i = 0; i <= 64; i++) begin
      if (i < 64) begin
        pix(12'(i), 12'd600, 12'h300 + 12'(i));
        push($sformatf("wrap_hc_%0d", i), 12'h300 + 12'(i));
      end
      tick();
      if (i >= 1) pop_rgb();
    end

    // mid-frame reset: black until the pipeline refills
    pix(12'd885, 12'd600, 12'h0a0);
    tick(); tick();
    chk("pre_reset_bg", vout.rgb, 12'h0a0);
    reset = 1'b1;
    #1;
    chk("reset_black", vout.rgb, 12'h000);
    chk("reset_xpos", xpos_out, 12'd885);
    tick();
    reset = 1'b0;
    tick();
    chk("refill_black", vout.rgb, 12'h000);
    tick();
    chk("refill_head", vout.rgb, 12'hf00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
